// File: rtl/sevenseg_scan_decoder_if.sv
// Bundle between a multiplexed 7-segment scan source (master) and the decoder (slave).
// Raw active-low DIGIT/DISPLAY lines in, decoded per-position codes and status out.
interface sevenseg_scan_decoder_if;
    logic [3:0]  DIGIT;
    logic [6:0]  DISPLAY;
    logic [15:0] codes;
    logic        frame_valid;
    logic        err_invalid;
    logic [7:0]  err_count;
    logic        scan_lost;

    modport master (
        output DIGIT, DISPLAY,
        input  codes, frame_valid, err_invalid, err_count, scan_lost
    );

    modport slave (
        input  DIGIT, DISPLAY,
        output codes, frame_valid, err_invalid, err_count, scan_lost
    );
endinterface

// File: rtl/sevenseg_scan_decoder.sv
// Recovers the four digit values from a sniffed, multiplexed 7-segment drive by
// waiting for each anode/segment pair to settle before capturing its decoded value.
module sevenseg_scan_decoder #(
    parameter int SETTLE      = 4,
    parameter int STALL_LIMIT = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    sevenseg_scan_decoder_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SETTLING, CAPTURED} state_e;

    localparam int                 STALL_W    = $clog2(STALL_LIMIT + 1);
    localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(STALL_LIMIT);
    localparam logic [3:0]         SETTLE_TGT = 4'(SETTLE - 2);
    localparam logic [3:0]         CODE_BAD   = 4'hE;

    logic [3:0]         digit_s1_q, digit_s2_q, prev_digit_q;
    logic [6:0]         disp_s1_q, disp_s2_q, prev_disp_q;
    state_e             state_q;
    logic [3:0]         settle_q;
    logic [3:0]         seen_q;
    logic [15:0]        codes_q;
    logic               frame_valid_q;
    logic               err_invalid_q;
    logic [7:0]         err_count_q;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               scan_lost_q;

    logic               sel_valid;
    logic [1:0]         pos;
    logic [3:0]         code;
    logic               pair_same;
    logic               accept;
    logic [3:0]         seen_d;

    function automatic logic [3:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'b1000000: return 4'd0;
            7'b1111001: return 4'd1;
            7'b0100100: return 4'd2;
            7'b0110000: return 4'd3;
            7'b0011001: return 4'd4;
            7'b0010010: return 4'd5;
            7'b0000010: return 4'd6;
            7'b1111000: return 4'd7;
            7'b0000000: return 4'd8;
            7'b0010000: return 4'd9;
            7'b1011100: return 4'd10;
            7'b1100011: return 4'd11;
            7'b1111111: return 4'd15;
            default:    return CODE_BAD;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sel_valid = 1'b0;
        pos       = 2'd0;
        case (digit_s2_q)
            4'b1110: begin sel_valid = 1'b1; pos = 2'd0; end
            4'b1101: begin sel_valid = 1'b1; pos = 2'd1; end
            4'b1011: begin sel_valid = 1'b1; pos = 2'd2; end
            4'b0111: begin sel_valid = 1'b1; pos = 2'd3; end
            default: begin sel_valid = 1'b0; pos = 2'd0; end
        endcase
    end

    assign code      = decode_seg(disp_s2_q);
    assign pair_same = (digit_s2_q == prev_digit_q) && (disp_s2_q == prev_disp_q);
    // settle_q counts matching consecutive pairs, so SETTLE stable cycles is SETTLE-1 matches.
    assign accept    = (state_q == SETTLING) && sel_valid && pair_same && (settle_q == SETTLE_TGT);
    assign seen_d    = seen_q | (4'b0001 << pos);
    assign stall_d   = accept ? '0 : ((stall_q == STALL_MAX) ? stall_q : stall_q + 1'b1);

    // NOTE: sequential state is written only with non-blocking assignments, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_s1_q    <= 4'b1111;
            digit_s2_q    <= 4'b1111;
            prev_digit_q  <= 4'b1111;
            disp_s1_q     <= 7'b1111111;
            disp_s2_q     <= 7'b1111111;
            prev_disp_q   <= 7'b1111111;
            state_q       <= IDLE;
            settle_q      <= 4'd0;
            seen_q        <= 4'd0;
            codes_q       <= 16'hFFFF;
            frame_valid_q <= 1'b0;
            err_invalid_q <= 1'b0;
            err_count_q   <= 8'd0;
            stall_q       <= '0;
            scan_lost_q   <= 1'b0;
        end else begin
            digit_s1_q    <= bus.DIGIT;
            digit_s2_q    <= digit_s1_q;
            disp_s1_q     <= bus.DISPLAY;
            disp_s2_q     <= disp_s1_q;
            prev_digit_q  <= digit_s2_q;
            prev_disp_q   <= disp_s2_q;
            frame_valid_q <= 1'b0;
            err_invalid_q <= 1'b0;
            stall_q       <= stall_d;
            scan_lost_q   <= (stall_d >= STALL_MAX);

            if (!sel_valid) begin
                state_q  <= IDLE;
                settle_q <= 4'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q  <= SETTLING;
                        settle_q <= 4'd0;
                    end
                    SETTLING: begin
                        if (!pair_same) begin
                            settle_q <= 4'd0;
                        end else if (accept) begin
                            state_q                    <= CAPTURED;
                            settle_q                   <= 4'd0;
                            codes_q[{pos, 2'b00} +: 4] <= code;
                            if (seen_d == 4'b1111) begin
                                frame_valid_q <= 1'b1;
                                seen_q        <= 4'd0;
                            end else begin
                                seen_q <= seen_d;
                            end
                            if (code == CODE_BAD) begin
                                err_invalid_q <= 1'b1;
                                if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
                            end
                        end else begin
                            settle_q <= settle_q + 4'd1;
                        end
                    end
                    CAPTURED: begin
                        if (!pair_same) begin
                            state_q  <= SETTLING;
                            settle_q <= 4'd0;
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        settle_q <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign bus.codes       = codes_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.err_invalid = err_invalid_q;
    assign bus.err_count   = err_count_q;
    assign bus.scan_lost   = scan_lost_q;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Directed bench for sevenseg_scan_decoder: settle timing, frame assembly, glitch
// rejection, invalid-pattern reporting, reset priority and scan-loss detection.
module tb_sevenseg_scan_decoder;

    localparam int SETTLE      = 4;
    localparam int STALL_LIMIT = 4096;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sevenseg_scan_decoder_if bus();

    sevenseg_scan_decoder #(
        .SETTLE      (SETTLE),
        .STALL_LIMIT (STALL_LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [3:0] s2_dig [4];
    logic [6:0] s2_seg [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int changed;
        int fv_count;
        int fv_cycle;
        int err_pulses;
        int err_cycle;
        int n;

        // Reset state
        rst         = 1'b1;
        bus.DIGIT   = 4'b1111;
        bus.DISPLAY = 7'b1111111;
        step(3);
        rst = 1'b0;
        check("rst_codes",       32'(bus.codes),       32'hFFFF);
        check("rst_frame_valid", 32'(bus.frame_valid), 32'd0);
        check("rst_err_invalid", 32'(bus.err_invalid), 32'd0);
        check("rst_err_count",   32'(bus.err_count),   32'd0);
        check("rst_scan_lost",   32'(bus.scan_lost),   32'd0);

        // Scenario 3: display toggling every 3 cycles on pos1 never settles
        changed   = 0;
        bus.DIGIT = 4'b1101;
        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 0) bus.DISPLAY = (i % 6 == 0) ? 7'b1111001 : 7'b0100100;
            step(1);
            if (bus.codes !== 16'hFFFF) changed++;
        end
        check("s3_no_accept", 32'(changed),          32'd0);
        check("s3_pos1_blank", 32'(bus.codes[7:4]),  32'hF);

        // Scenario 1: "2" on pos0 appears exactly 2+SETTLE clocks after being applied
        fv_count    = 0;
        bus.DIGIT   = 4'b1110;
        bus.DISPLAY = 7'b0100100;
        for (int i = 1; i <= 6; i++) begin
            step(1);
            if (bus.frame_valid) fv_count++;
            if (i == 5) check("s1_before_settle", 32'(bus.codes), 32'hFFFF);
        end
        check("s1_codes",    32'(bus.codes), 32'hFFF2);
        check("s1_no_frame", 32'(fv_count),  32'd0);

        // Scenario 2: full scan 1, up-arrow, 3, 0 across pos0..pos3, 8 cycles each
        s2_dig[0] = 4'b1110; s2_seg[0] = 7'b1111001;
        s2_dig[1] = 4'b1101; s2_seg[1] = 7'b1011100;
        s2_dig[2] = 4'b1011; s2_seg[2] = 7'b0110000;
        s2_dig[3] = 4'b0111; s2_seg[3] = 7'b1000000;
        fv_count = 0;
        fv_cycle = 0;
        n        = 0;
        for (int p = 0; p < 4; p++) begin
            bus.DIGIT   = s2_dig[p];
            bus.DISPLAY = s2_seg[p];
            for (int c = 0; c < 8; c++) begin
                step(1);
                n++;
                if (bus.frame_valid) begin
                    fv_count++;
                    fv_cycle = n;
                    check("s2_codes_at_frame", 32'(bus.codes), 32'h03A1);
                end
            end
        end
        check("s2_codes",       32'(bus.codes),  32'h03A1);
        check("s2_frame_count", 32'(fv_count),   32'd1);
        check("s2_frame_cycle", 32'(fv_cycle),   32'd30);
        check("s2_mask_clear",  32'(dut.seen_q), 32'd0);

        // Scenario 4: unrecognised pattern on pos2 reported once, even when held
        err_pulses  = 0;
        err_cycle   = 0;
        bus.DIGIT   = 4'b1011;
        bus.DISPLAY = 7'b0101010;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            if (bus.err_invalid) begin
                err_pulses++;
                err_cycle = i;
            end
        end
        check("s4_codes",      32'(bus.codes),     32'h0EA1);
        check("s4_err_pulses", 32'(err_pulses),    32'd1);
        check("s4_err_cycle",  32'(err_cycle),     32'd6);
        check("s4_err_count",  32'(bus.err_count), 32'd1);

        // Scenario 6: reset held across the would-be acceptance edge discards it
        bus.DIGIT   = 4'b0111;
        bus.DISPLAY = 7'b0000000;
        step(4);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        check("s6_codes",       32'(bus.codes),       32'hFFFF);
        check("s6_err_count",   32'(bus.err_count),   32'd0);
        check("s6_mask",        32'(dut.seen_q),      32'd0);
        check("s6_frame_valid", 32'(bus.frame_valid), 32'd0);
        step(5);
        check("s6_no_early_accept", 32'(bus.codes), 32'hFFFF);
        step(1);
        check("s6_accept_after_release", 32'(bus.codes), 32'h8FFF);

        // Scenario 5: no select for STALL_LIMIT cycles raises scan_lost
        bus.DIGIT = 4'b1111;
        step(STALL_LIMIT - 1);
        check("s5_below_limit", 32'(bus.scan_lost), 32'd0);
        step(1);
        check("s5_at_limit", 32'(bus.scan_lost), 32'd1);
        step(10);
        check("s5_held", 32'(bus.scan_lost), 32'd1);
        bus.DIGIT   = 4'b1110;
        bus.DISPLAY = 7'b1100011;
        step(5);
        check("s5_lost_before_accept", 32'(bus.scan_lost), 32'd1);
        step(1);
        check("s5_recovered", 32'(bus.scan_lost), 32'd0);
        check("s5_codes",     32'(bus.codes),     32'h8FFB);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan_decoder.md
SEVENSEG_SCAN_DECODER -- requirements
Module: sevenseg_scan_decoder

Interface
REQ-001 SHALL have parameter SETTLE, default 4, giving the consecutive stable cycles (range 2..15) needed before a digit/segment pair is accepted.
REQ-002 SHALL have parameter STALL_LIMIT, default 4096, giving the cycles without an accepted pair before scan_lost asserts.
REQ-003 SHALL have one clock; reset is synchronous and active-high: port clk (input, 1, rising-edge system clock).
REQ-004 SHALL have port rst (input, 1): synchronous active-high reset.
REQ-005 SHALL have port DIGIT (input, 4): active-low anode select; 4'b1110 is the rightmost position (pos0) through 4'b0111 for the leftmost (pos3).
REQ-006 SHALL have port DISPLAY (input, 7): active-low segments, bit6=g down to bit0=a.
REQ-007 SHALL have port codes (output, 16): decoded value per position; [3:0] is pos0 through [15:12] is pos3.
REQ-008 SHALL have port frame_valid (output, 1): one-cycle pulse when all four positions have been captured.
REQ-009 SHALL have port err_invalid (output, 1): one-cycle pulse on acceptance of an unrecognised segment pattern.
REQ-010 SHALL have port err_count (output, 8): saturating count of err_invalid pulses.
REQ-011 SHALL have port scan_lost (output, 1): level; no acceptance for at least STALL_LIMIT cycles.

Function
REQ-012 SHALL pass DIGIT and DISPLAY through a 2-flop synchroniser; all further logic uses the synchronised pair.
REQ-013 SHALL decode DISPLAY as follows:
- 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4
- 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9
- 1011100->10 (up arrow), 1100011->11 (down arrow), 1111111->15 (blank)
- any other pattern->14 (invalid)
REQ-014 SHALL implement states IDLE, SETTLING and CAPTURED.
REQ-015 SHALL treat a synchronised DIGIT that is not one of the four one-cold values as no-select, forcing IDLE and clearing the settle counter.
REQ-016 SHALL transition IDLE->SETTLING when a valid select appears, and SHALL clear the settle counter to 0.
REQ-017 SHALL, in SETTLING, increment the settle counter each cycle the pair equals the previous cycle's pair, and clear it on any change.
REQ-018 SHALL accept the pair when the pair has been identical for SETTLE consecutive cycles.
REQ-019 SHALL, on acceptance, write the decoded code into the selected position and enter CAPTURED.
REQ-020 SHALL, in CAPTURED, perform no further acceptance until the pair changes. On a change SHALL go to SETTLING if the select is valid, otherwise to IDLE.
REQ-021 SHALL make the code visible on codes exactly 2+SETTLE clocks after a pair is applied and held at the inputs.
REQ-022 SHALL keep a 4-bit seen mask and set the bit for the position on each acceptance. Re-acceptance of an already-seen position SHALL overwrite its code and leave the mask unchanged.
REQ-023 SHALL, on the acceptance that makes the mask 4'b1111, pulse frame_valid in the same cycle that the code updates, and clear the mask to 4'b0000.
REQ-024 SHALL pulse err_invalid in the cycle that code 14 is written, and increment err_count, saturating at 255.
REQ-025 SHALL run a stall counter that clears on acceptance and otherwise increments, saturating at STALL_LIMIT.
REQ-026 SHALL assert scan_lost while the stall counter is at or above STALL_LIMIT, and deassert it in the cycle after the next acceptance.

Reset
REQ-027 SHALL, when rst=1 at a clock edge, set codes=16'hFFFF and frame_valid=0, err_invalid=0, err_count=0, scan_lost=0.
REQ-028 SHALL, when rst=1 at a clock edge, set the mask to 0, the settle counter to 0, the stall counter to 0 and the state to IDLE.
REQ-029 SHALL, when rst=1 at a clock edge, load the synchroniser flops with DIGIT=4'b1111 and DISPLAY=7'b1111111.
REQ-030 SHALL give rst priority over all other activity, including when it arrives mid-SETTLING or in the same cycle as an acceptance; the acceptance is discarded.

Verification
REQ-031 SHALL cover scenario 1 (SETTLE=4): hold DIGIT=1110, DISPLAY=0100100 -> codes[3:0]=2 exactly 6 clocks later, with no frame_valid.
REQ-032 SHALL cover scenario 2: scan pos0..pos3 with patterns for 1, up arrow, 3, 0, each held 8 cycles -> codes=16'h03A1 and a single frame_valid pulse on pos3 acceptance.
REQ-033 SHALL cover scenario 3: toggle DISPLAY every 3 cycles on DIGIT=1101 for 30 cycles -> codes[7:4] stays F, with no acceptance.
REQ-034 SHALL cover scenario 4: hold DIGIT=1011, DISPLAY=0101010 -> codes[11:8]=14, one err_invalid pulse and err_count=1; holding longer gives no second pulse.
REQ-035 SHALL cover scenario 5: hold DIGIT=1111 for STALL_LIMIT+10 cycles -> scan_lost=1; then hold a valid pair -> scan_lost=0 after acceptance.
REQ-036 SHALL cover scenario 6: assert rst one cycle before an expected acceptance -> codes=FFFF, err_count=0 and mask=0; the acceptance does not occur.
